// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock time keeper:
//   - BCD digit widths for seconds, minutes and hours
//   - the seconds/minutes maximum value (59)
//   - one-hot mode encodings, ordered {hour_setup, minute_setup,
//     second_setup, normal}
//   - a helper that tells whether a mode vector is exactly one-hot
// ----------------------------------------------------------------------------
package clock_pkg;

    localparam int SEC_TENS_W = 3;
    localparam int SEC_ONES_W = 4;
    localparam int MIN_TENS_W = 3;
    localparam int MIN_ONES_W = 4;
    localparam int HR_TENS_W  = 2;
    localparam int HR_ONES_W  = 4;

    localparam int MS_MAX = 59;

    localparam int MODE_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_NORMAL = 4'b0001,
        MODE_SEC    = 4'b0010,
        MODE_MIN    = 4'b0100,
        MODE_HR     = 4'b1000
    } mode_t;

    // True when exactly one bit of the mode vector is set.
    function automatic logic mode_is_one_hot(input logic [MODE_W-1:0] m);
        return (m != {MODE_W{1'b0}}) &&
               ((m & (m - {{(MODE_W-1){1'b0}}, 1'b1})) == {MODE_W{1'b0}});
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that counts 0..MAX_VAL and wraps to 00.
//   CLK       in  clock, rising edge
//   reset     in  asynchronous active-high reset, clears to 00
//   en        in  advance by one on this edge
//   tens      out registered tens digit (TENS_W bits)
//   ones      out registered ones digit
//   carry_out out high when en is set and the counter is at MAX_VAL, i.e. the
//                 count wraps on this edge (combinational, for chaining)
// An out-of-range value (never reachable in normal operation) is forced back
// to 00 on the next edge so a digit cannot stay illegal.
// ----------------------------------------------------------------------------
module bcd_mod_counter #(
    parameter int MAX_VAL = 59,
    parameter int TENS_W  = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              en,
    output logic [TENS_W-1:0] tens,
    output logic [3:0]        ones,
    output logic              carry_out
);

    localparam logic [TENS_W-1:0] MAX_TENS = TENS_W'(MAX_VAL / 10);
    localparam logic [3:0]        MAX_ONES = 4'(MAX_VAL % 10);

    logic [TENS_W-1:0] tens_r;
    logic [TENS_W-1:0] tens_next_s;
    logic [3:0]        ones_r;
    logic [3:0]        ones_next_s;
    logic              at_max_s;
    logic              legal_s;

    assign at_max_s  = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
    assign legal_s   = (ones_r <= 4'd9) &&
                       ((tens_r < MAX_TENS) || ((tens_r == MAX_TENS) && (ones_r <= MAX_ONES)));
    assign carry_out = en & at_max_s;

    // Next-count computation with wrap at MAX_VAL and illegal-value recovery.
    always_comb begin
        tens_next_s = tens_r;
        ones_next_s = ones_r;
        if (!legal_s) begin
            tens_next_s = {TENS_W{1'b0}};
            ones_next_s = 4'd0;
        end else if (en) begin
            if (at_max_s) begin
                tens_next_s = {TENS_W{1'b0}};
                ones_next_s = 4'd0;
            end else if (ones_r == 4'd9) begin
                tens_next_s = tens_r + TENS_W'(1'b1);
                ones_next_s = 4'd0;
            end else begin
                ones_next_s = ones_r + 4'd1;
            end
        end else begin
            tens_next_s = tens_r;
            ones_next_s = ones_r;
        end
    end

    // Digit registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tens_r <= {TENS_W{1'b0}};
            ones_r <= 4'd0;
        end else begin
            tens_r <= tens_next_s;
            ones_r <= ones_next_s;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/clock_time_keeper.sv
// ----------------------------------------------------------------------------
// clock_time_keeper
// HH:MM:SS time keeper with BCD outputs, a run mode and three setup modes.
//   CLK                 in  clock, rising edge
//   reset               in  asynchronous active-high reset -> 00:00:00
//   tick                in  1 Hz enable, one CLK wide
//   normal              in  run mode (one-hot with the setup bits)
//   second_setup        in  seconds field selected for setting
//   minute_setup        in  minutes field selected for setting
//   hour_setup          in  hours field selected for setting
//   inc                 in  asynchronous active-low pushbutton, idle high
//   sec_tens/sec_ones   out seconds BCD digits (registered)
//   min_tens/min_ones   out minutes BCD digits (registered)
//   hr_tens/hr_ones     out hours BCD digits (registered)
//   blink               out display enable for the selected field
//   mode_err            out registered flag, mode bits not exactly one-hot
// The button is synchronised, its falling edge is detected and registered as
// inc_pulse_r, so a digit moves SYNC_STAGES+2 edges after the fall on inc.
// ----------------------------------------------------------------------------
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  normal,
    input  logic                  second_setup,
    input  logic                  minute_setup,
    input  logic                  hour_setup,
    input  logic                  inc,
    output logic [SEC_TENS_W-1:0] sec_tens,
    output logic [SEC_ONES_W-1:0] sec_ones,
    output logic [MIN_TENS_W-1:0] min_tens,
    output logic [MIN_ONES_W-1:0] min_ones,
    output logic [HR_TENS_W-1:0]  hr_tens,
    output logic [HR_ONES_W-1:0]  hr_ones,
    output logic                  blink,
    output logic                  mode_err
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SYNC_N-1:0]  sync_r;
    logic               edge_prev_r;
    // fill_r marks which pipeline stages hold a real sample taken after reset;
    // a fall is only trusted once both compared samples are real, so holding
    // the button through reset release produces no pulse.
    logic [SYNC_N:0]    fill_r;
    logic               inc_pulse_r;

    logic [MODE_W-1:0]  mode_s;
    logic [MODE_W-1:0]  mode_prev_r;
    logic               mode_valid_s;
    logic               run_s;
    logic               sel_sec_s;
    logic               sel_min_s;
    logic               sel_hr_s;

    logic               sec_en_s;
    logic               min_en_s;
    logic               hr_en_s;
    logic               sec_carry_s;
    logic               min_carry_s;
    logic               hr_carry_s;

    logic               blink_r;
    logic               blink_next_s;
    logic               mode_err_r;

    assign mode_s       = {hour_setup, minute_setup, second_setup, normal};
    assign mode_valid_s = mode_is_one_hot(mode_s);

    // Button synchroniser, falling-edge detector and registered pulse.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_r      <= {SYNC_N{1'b1}};
            edge_prev_r <= 1'b1;
            fill_r      <= {(SYNC_N+1){1'b0}};
            inc_pulse_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_N-2:0], inc};
            edge_prev_r <= sync_r[SYNC_N-1];
            fill_r      <= {fill_r[SYNC_N-1:0], 1'b1};
            inc_pulse_r <= fill_r[SYNC_N] & edge_prev_r & ~sync_r[SYNC_N-1];
        end
    end

    // Mode decode; anything not one-hot selects nothing so all fields hold.
    always_comb begin
        run_s     = 1'b0;
        sel_sec_s = 1'b0;
        sel_min_s = 1'b0;
        sel_hr_s  = 1'b0;
        case (mode_s)
            MODE_NORMAL: run_s     = 1'b1;
            MODE_SEC:    sel_sec_s = 1'b1;
            MODE_MIN:    sel_min_s = 1'b1;
            MODE_HR:     sel_hr_s  = 1'b1;
            default: begin
                run_s     = 1'b0;
                sel_sec_s = 1'b0;
                sel_min_s = 1'b0;
                sel_hr_s  = 1'b0;
            end
        endcase
    end

    // Run mode ripples carries through all fields in one cycle; setup mode
    // bumps only the selected field, and its carry is not propagated.
    assign sec_en_s = (run_s & tick) | (sel_sec_s & inc_pulse_r);
    assign min_en_s = (run_s & sec_carry_s) | (sel_min_s & inc_pulse_r);
    assign hr_en_s  = (run_s & min_carry_s) | (sel_hr_s & inc_pulse_r);

    bcd_mod_counter #(.MAX_VAL(MS_MAX), .TENS_W(SEC_TENS_W)) u_sec (
        .CLK       (CLK),
        .reset     (reset),
        .en        (sec_en_s),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry_s)
    );

    bcd_mod_counter #(.MAX_VAL(MS_MAX), .TENS_W(MIN_TENS_W)) u_min (
        .CLK       (CLK),
        .reset     (reset),
        .en        (min_en_s),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry_s)
    );

    bcd_mod_counter #(.MAX_VAL(HOUR_MAX), .TENS_W(HR_TENS_W)) u_hr (
        .CLK       (CLK),
        .reset     (reset),
        .en        (hr_en_s),
        .tens      (hr_tens),
        .ones      (hr_ones),
        .carry_out (hr_carry_s)
    );

    // Blink next state: solid when invalid, on a mode change or in run mode;
    // toggles on tick while a field is being set.
    always_comb begin
        blink_next_s = blink_r;
        if (!mode_valid_s) begin
            blink_next_s = 1'b1;
        end else if (mode_s != mode_prev_r) begin
            blink_next_s = 1'b1;
        end else if (run_s) begin
            blink_next_s = 1'b1;
        end else if (tick) begin
            blink_next_s = ~blink_r;
        end else begin
            blink_next_s = blink_r;
        end
    end

    // Blink, previous-mode and mode error registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            blink_r     <= 1'b1;
            mode_prev_r <= MODE_NORMAL;
            mode_err_r  <= 1'b0;
        end else begin
            blink_r     <= blink_next_s;
            mode_prev_r <= mode_s;
            mode_err_r  <= ~mode_valid_s;
        end
    end

    assign blink    = blink_r;
    assign mode_err = mode_err_r;

endmodule

// File: tb/tb_clock_time_keeper.sv
// ----------------------------------------------------------------------------
// tb_clock_time_keeper
// Directed stimulus pushes hand-computed expected time/blink/mode_err values
// into a queue; a monitor pops and compares them on the falling clock edge.
// Expected time is written as 24'hHHMMSS.
// ----------------------------------------------------------------------------
module tb_clock_time_keeper;

    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       reset;
    logic       tick;
    logic       normal;
    logic       second_setup;
    logic       minute_setup;
    logic       hour_setup;
    logic       inc;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic       blink;
    logic       mode_err;

    clock_time_keeper #(.SYNC_STAGES(SYNC), .HOUR_MAX(23)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .tick         (tick),
        .normal       (normal),
        .second_setup (second_setup),
        .minute_setup (minute_setup),
        .hour_setup   (hour_setup),
        .inc          (inc),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .hr_tens      (hr_tens),
        .hr_ones      (hr_ones),
        .blink        (blink),
        .mode_err     (mode_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [23:0] t;
        logic        b;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_x;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] dut_t;

    assign dut_t = {2'b00, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

    task automatic expect_st(input string nm, input logic [23:0] t, input logic b, input logic e);
        exp_t x;
        x.name = nm;
        x.t    = t;
        x.b    = b;
        x.e    = e;
        exp_q.push_back(x);
    endtask

    // Monitor: compare every queued expectation at the next falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            while (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                n_cmp++;
                if (dut_t !== mon_x.t || blink !== mon_x.b || mode_err !== mon_x.e) begin
                    n_bad++;
                    $display("FAIL %s: got time=%h blink=%b mode_err=%b, expected time=%h blink=%b mode_err=%b",
                             mon_x.name, dut_t, blink, mode_err, mon_x.t, mon_x.b, mon_x.e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_mode(input logic [3:0] m);
        {hour_setup, minute_setup, second_setup, normal} = m;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic press();
        inc = 1'b0;
        step(5);
        inc = 1'b1;
        step(5);
    endtask

    task automatic press_n(input int n);
        for (int k = 0; k < n; k++) press();
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        inc   = 1'b1;
        set_mode(4'b0001);
        step(2);
        expect_st("reset_state", 24'h000000, 1'b1, 1'b0);
        step(1);
        reset = 1'b0;
        step(2);

        // Run mode: 61 ticks with carry into minutes.
        for (int i = 1; i <= 61; i++) begin
            do_tick();
            if (i == 1)  expect_st("tick_1",  24'h000001, 1'b1, 1'b0);
            if (i == 59) expect_st("tick_59", 24'h000059, 1'b1, 1'b0);
            if (i == 60) expect_st("tick_60", 24'h000100, 1'b1, 1'b0);
            step(1);
        end
        expect_st("tick_61", 24'h000101, 1'b1, 1'b0);
        step(1);

        // Button ignored in run mode.
        press();
        expect_st("normal_inc_ignored", 24'h000101, 1'b1, 1'b0);
        step(1);

        // Fresh start, seconds at 07, then minute setup.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 7; i++) begin
            do_tick();
            step(1);
        end
        expect_st("sec_07", 24'h000007, 1'b1, 1'b0);
        set_mode(4'b0100);
        step(2);
        expect_st("min_setup_enter", 24'h000007, 1'b1, 1'b0);
        press_n(60);
        expect_st("min_wrap_60", 24'h000007, 1'b1, 1'b0);
        press();
        expect_st("min_61", 24'h000107, 1'b1, 1'b0);
        step(1);

        // Ticks during setup freeze time and toggle blink.
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            expect_st("setup_tick_blink", 24'h000107, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            step(1);
        end

        // Preload 23:59:59.
        press_n(58);
        expect_st("min_59", 24'h005907, 1'b0, 1'b0);
        set_mode(4'b0010);
        step(1);
        press_n(52);
        expect_st("sec_59", 24'h005959, 1'b1, 1'b0);
        set_mode(4'b1000);
        step(1);
        press_n(23);
        expect_st("hr_23", 24'h235959, 1'b1, 1'b0);

        // Hour wrap latency: unchanged after 3 edges, 00 after the 4th.
        inc = 1'b0;
        step(3);
        expect_st("hr_lat_3", 24'h235959, 1'b1, 1'b0);
        step(1);
        expect_st("hr_lat_4", 24'h005959, 1'b1, 1'b0);
        step(2);
        inc = 1'b1;
        step(5);
        press_n(23);
        expect_st("hr_23_again", 24'h235959, 1'b1, 1'b0);

        // Full rollover on one tick.
        set_mode(4'b0001);
        step(1);
        expect_st("normal_return", 24'h235959, 1'b1, 1'b0);
        do_tick();
        expect_st("rollover", 24'h000000, 1'b1, 1'b0);
        step(1);

        // Invalid mode bits.
        for (int i = 0; i < 3; i++) begin
            do_tick();
            step(1);
        end
        set_mode(4'b0110);
        step(1);
        expect_st("err_set", 24'h000003, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
        end
        tick = 1'b0;
        expect_st("err_frozen", 24'h000003, 1'b1, 1'b1);
        set_mode(4'b0001);
        step(1);
        expect_st("err_clear", 24'h000003, 1'b1, 1'b0);
        do_tick();
        expect_st("resume", 24'h000004, 1'b1, 1'b0);
        step(1);
        set_mode(4'b0000);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        expect_st("mode_zero", 24'h000004, 1'b1, 1'b1);
        set_mode(4'b0001);
        step(1);
        expect_st("mode_zero_clear", 24'h000004, 1'b1, 1'b0);
        step(1);

        // Reset mid-press with inc held low through release.
        set_mode(4'b1000);
        step(2);
        inc = 1'b0;
        step(1);
        reset = 1'b1;
        expect_st("async_reset", 24'h000000, 1'b1, 1'b0);
        step(2);
        reset = 1'b0;
        step(10);
        expect_st("no_pulse_after_reset", 24'h000000, 1'b1, 1'b0);
        inc = 1'b1;
        step(5);
        press();
        expect_st("one_inc", 24'h010000, 1'b1, 1'b0);
        step(5);
        expect_st("no_extra_inc", 24'h010000, 1'b1, 1'b0);
        step(2);

        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
            n_bad = n_bad + exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_time_keeper.md
CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on the inc button input (minimum 2).
REQ-002 Parameter HOUR_MAX, default 23: highest hour value before wrap to 00.
REQ-003 CLK  input  1  single clock, rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 tick  input  1  1 Hz enable, one CLK cycle wide, synchronous to CLK.
REQ-006 normal  input  1  one-hot mode bit, run mode, registered and synchronous to CLK.
REQ-007 second_setup  input  1  one-hot mode bit, seconds field selected for setting.
REQ-008 minute_setup  input  1  one-hot mode bit, minutes field selected for setting.
REQ-009 hour_setup  input  1  one-hot mode bit, hours field selected for setting.
REQ-010 inc  input  1  active-low asynchronous pushbutton, idle high.
REQ-011 sec_tens  output  3  BCD seconds tens digit, 0-5.
REQ-012 sec_ones  output  4  BCD seconds ones digit, 0-9.
REQ-013 min_tens  output  3  BCD minutes tens digit, 0-5.
REQ-014 min_ones  output  4  BCD minutes ones digit, 0-9.
REQ-015 hr_tens  output  2  BCD hours tens digit, 0-2.
REQ-016 hr_ones  output  4  BCD hours ones digit, 0-9.
REQ-017 blink  output  1  display enable for the selected field; 1 means digits visible.
REQ-018 mode_err  output  1  registered flag; 1 while the mode bits are not exactly one-hot.

Function
REQ-019 inc SHALL pass through SYNC_STAGES flops. A falling edge on the synchronised signal SHALL produce a one-cycle inc_pulse exactly SYNC_STAGES+1 rising CLK edges after the fall on inc.
REQ-020 In normal mode, a tick SHALL advance seconds by 1. 59->00 carries to minutes; minutes 59->00 carries to hours; hours HOUR_MAX->00. All carries resolve in the same cycle, so 23:59:59 becomes 00:00:00 on one edge.
REQ-021 In normal mode, inc_pulse SHALL be ignored.
REQ-022 In any setup mode, tick SHALL NOT advance time; the clock is halted.
REQ-023 In a setup mode, inc_pulse SHALL increment only the selected field by 1. It wraps 59->00 (seconds, minutes) or HOUR_MAX->00 (hours), with no carry into other fields.
REQ-024 On a cycle where tick and inc_pulse coincide, only the action valid for the current mode SHALL occur.
REQ-025 If the mode bits are all-zero or multi-hot, all time digits SHALL hold, blink SHALL be 1, and mode_err SHALL be 1 on the next edge. mode_err SHALL clear on the first edge after the mode bits are valid one-hot again.
REQ-026 In a setup mode, blink SHALL toggle on each tick. In normal mode, blink SHALL be forced to 1 on the next edge.
REQ-027 On a mode change, blink SHALL restart at 1.
REQ-028 Time outputs SHALL be registered; updated digits are visible one cycle after the qualifying tick or inc_pulse edge.
REQ-029 Each BCD digit SHALL never hold a value outside its legal range.

Reset
REQ-030 Asserting reset SHALL immediately force the time to 00:00:00, blink=1, mode_err=0, and all synchroniser flops and the edge-detect register to 1 (idle).
REQ-031 Releasing reset while inc is held low SHALL NOT generate an inc_pulse; only a subsequent fall generates one.
REQ-032 Reset asserted mid-count or mid-setup SHALL abandon the operation with no residual pulse after release.

Structure
REQ-033 The shared package clock_pkg SHALL hold the digit widths, the minute/second maximum (59) and the mode one-hot encodings.
REQ-034 The sub-module bcd_mod_counter SHALL be a two-digit BCD counter with enable, parameterised maximum value, wrap and carry_out. It SHALL be instantiated three times (seconds, minutes, hours).

Verification
REQ-035 Reset, normal mode, 61 ticks -> time reads 00:01:01; blink stays 1.
REQ-036 Preload via setup to 23:59:59, return to normal, one tick -> 00:00:00 on a single edge.
REQ-037 minute_setup, 61 inc falls -> minutes 01 (wrapped through 00), hours and seconds unchanged; 5 ticks during setup leave seconds unchanged and toggle blink 5 times.
REQ-038 hour_setup at hour 23, one inc fall -> hours 00 after exactly SYNC_STAGES+1 edges plus one register stage; minutes unchanged.
REQ-039 mode bits 0110 for 10 cycles with ticks -> time frozen, mode_err=1; return to 0001 -> mode_err=0 next edge and counting resumes.
REQ-040 Hold inc low through reset release -> no increment; release inc, press again -> exactly one increment.
